// File: rtl/opentdc_rr_arbiter.sv
// Round-robin grant of up to four TDC channels into a tagged first-word-fall-through FIFO.
// Grant registered one cycle after request; no grant while the FIFO is full (request stays pending, stall flagged).
module opentdc_rr_arbiter #(
    parameter int TS_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [3:0]                 req_i,
    input  logic [4*TS_W-1:0]          ts_i,
    input  logic [3:0]                 en_i,
    output logic [3:0]                 ack_o,
    input  logic                       rd_i,
    output logic [TS_W+1:0]            rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       stall_o,
    input  logic                       clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TS_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [3:0]        ack_q, ack_d;
    logic [1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              stall_q, stall_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];

    logic [TS_W-1:0]   ts_ch [4];
    logic [3:0]        elig;
    logic              room;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic              push;
    logic              pop;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ts_ch[k] = ts_i[k*TS_W +: TS_W];
        end
    end

    // The channel being acked still holds its request this cycle, so it is masked out.
    always_comb begin
        elig    = req_i & en_i & ~ack_q;
        room    = (count_q < DEPTH_C);
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        cand    = rr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_q + 2'(i);
            if (!gnt_vld && room && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        push = gnt_vld;
        pop  = rd_i && !empty_q;

        ack_d = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
        rr_d  = gnt_vld ? gnt_idx : rr_q;

        head_d = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d = push ? tail_q + PTR_W'(1) : tail_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);

        // Set has priority over clear so a refusal in the clearing cycle is not lost.
        stall_d = stall_q;
        if (clr_i) begin
            stall_d = 1'b0;
        end
        if (!room && (|(req_i & en_i))) begin
            stall_d = 1'b1;
        end

        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
        end
        if (push) begin
            mem_d[tail_q] = {gnt_idx, ts_ch[gnt_idx]};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 4'b0000;
            rr_q    <= 2'd3;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            stall_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            stall_q <= stall_d;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    assign ack_o     = ack_q;
    assign rd_data_o = mem_q[head_q];
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign count_o   = count_q;
    assign stall_o   = stall_q;

endmodule

// File: tb/tb_opentdc_rr_arbiter.sv
// Directed vector table plus hand-written wrap-around and asynchronous reset sequences.
module tb_opentdc_rr_arbiter;

    localparam int TS_W  = 32;
    localparam int DEPTH = 4;

    localparam logic [33:0] D0 = {2'd0, 32'h0000_0A5A};
    localparam logic [33:0] D1 = {2'd1, 32'h0000_0111};
    localparam logic [33:0] D2 = {2'd2, 32'h0000_0222};
    localparam logic [33:0] D3 = {2'd3, 32'h0000_0333};

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i = 1'b0;
    logic [3:0]        req_i    = 4'b0000;
    logic [4*TS_W-1:0] ts_i;
    logic [3:0]        en_i     = 4'b1111;
    logic [3:0]        ack_o;
    logic              rd_i     = 1'b0;
    logic [TS_W+1:0]   rd_data_o;
    logic              empty_o;
    logic              full_o;
    logic [2:0]        count_o;
    logic              stall_o;
    logic              clr_i    = 1'b0;

    logic [TS_W-1:0]   ts_arr [4];
    assign ts_i = {ts_arr[3], ts_arr[2], ts_arr[1], ts_arr[0]};

    int errors = 0;
    int checks = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    opentdc_rr_arbiter #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_i     (req_i),
        .ts_i      (ts_i),
        .en_i      (en_i),
        .ack_o     (ack_o),
        .rd_i      (rd_i),
        .rd_data_o (rd_data_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .stall_o   (stall_o),
        .clr_i     (clr_i)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  en;
        logic        rd;
        logic        clr;
        logic [3:0]  ack;
        logic [2:0]  cnt;
        logic        emp;
        logic        ful;
        logic        stl;
        logic        chk_d;
        logic [33:0] dat;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ack"},   64'(ack_o),     64'h0);
        chk({tag, "_count"}, 64'(count_o),   64'h0);
        chk({tag, "_empty"}, 64'(empty_o),   64'h1);
        chk({tag, "_full"},  64'(full_o),    64'h0);
        chk({tag, "_stall"}, 64'(stall_o),   64'h0);
        chk({tag, "_data"},  64'(rd_data_o), 64'h0);
    endtask

    task automatic set_default_ts();
        ts_arr[0] = 32'h0000_0A5A;
        ts_arr[1] = 32'h0000_0111;
        ts_arr[2] = 32'h0000_0222;
        ts_arr[3] = 32'h0000_0333;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] exp_q [$];
        int          guard;

        // single request, then reset, fairness, full+pop, stall clear, reset, mask, drain, empty pop
        vt[0]  = '{1'b0, 4'b0001, 4'b1111, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[1]  = '{1'b0, 4'b0001, 4'b1111, 1'b0, 1'b0, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[2]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 34'h0};
        vt[3]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 34'h0};
        vt[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[6]  = '{1'b0, 4'b1110, 4'b1111, 1'b0, 1'b0, 4'b0100, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[7]  = '{1'b0, 4'b1100, 4'b1111, 1'b0, 1'b0, 4'b1000, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, D0};
        vt[8]  = '{1'b0, 4'b1011, 4'b1111, 1'b0, 1'b0, 4'b0000, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, D0};
        vt[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, D0};
        vt[10] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, D1};
        vt[11] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, D1};
        vt[12] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, D1};
        vt[13] = '{1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1, 4'b0000, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, D1};
        vt[14] = '{1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 34'h0};
        vt[15] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[16] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[17] = '{1'b0, 4'b1111, 4'b1011, 1'b0, 1'b0, 4'b1000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[18] = '{1'b0, 4'b1111, 4'b1011, 1'b1, 1'b0, 4'b0001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, D1};
        vt[19] = '{1'b0, 4'b0000, 4'b1011, 1'b1, 1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, D3};
        vt[20] = '{1'b0, 4'b0000, 4'b1011, 1'b1, 1'b0, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, D0};
        vt[21] = '{1'b0, 4'b0000, 4'b1011, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 34'h0};
        vt[22] = '{1'b0, 4'b0000, 4'b1011, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 34'h0};

        set_default_ts();
        #1 wb_rst_i = 1'b1;
        #1 chk_reset_state("init");

        for (int r = 0; r < 23; r++) begin
            wb_rst_i = vt[r].rst;
            req_i    = vt[r].req;
            en_i     = vt[r].en;
            rd_i     = vt[r].rd;
            clr_i    = vt[r].clr;
            @(posedge wb_clk_i);
            #1;
            chk($sformatf("row%0d_ack", r),   64'(ack_o),   64'(vt[r].ack));
            chk($sformatf("row%0d_count", r), 64'(count_o), 64'(vt[r].cnt));
            chk($sformatf("row%0d_empty", r), 64'(empty_o), 64'(vt[r].emp));
            chk($sformatf("row%0d_full", r),  64'(full_o),  64'(vt[r].ful));
            chk($sformatf("row%0d_stall", r), 64'(stall_o), 64'(vt[r].stl));
            if (vt[r].chk_d) begin
                chk($sformatf("row%0d_data", r), 64'(rd_data_o), 64'(vt[r].dat));
            end
        end
        rd_i  = 1'b0;
        clr_i = 1'b0;
        en_i  = 4'b1111;

        // Wrap-around: nine tagged entries with interleaved pops.
        for (int i = 1; i <= 9; i++) begin
            automatic int ch = (i - 1) % 4;
            ts_arr[ch] = 32'(i);
            req_i      = 4'b0001 << ch;
            rd_i       = (i % 3 != 1);
            if (rd_i) begin
                chk($sformatf("wrap%0d_data", i), 64'(rd_data_o), 64'(exp_q[0]));
            end
            @(posedge wb_clk_i);
            #1;
            if (rd_i) begin
                void'(exp_q.pop_front());
            end
            exp_q.push_back({2'(ch), 32'(i)});
            chk($sformatf("wrap%0d_ack", i), 64'(ack_o), 64'(4'b0001 << ch));
        end
        req_i = 4'b0000;
        guard = 0;
        while (exp_q.size() > 0 && guard < DEPTH + 2) begin
            chk($sformatf("drain%0d_data", guard), 64'(rd_data_o), 64'(exp_q[0]));
            rd_i = 1'b1;
            @(posedge wb_clk_i);
            #1;
            void'(exp_q.pop_front());
            guard++;
        end
        rd_i = 1'b0;
        chk("drain_left", 64'(exp_q.size()), 64'h0);
        chk("drain_empty", 64'(empty_o), 64'h1);
        chk("drain_count", 64'(count_o), 64'h0);

        // Reset mid-burst: fill, refuse (stall), pop one, then reset between edges.
        wb_rst_i = 1'b1;
        #2 wb_rst_i = 1'b0;
        set_default_ts();
        req_i = 4'b1111;
        repeat (5) @(posedge wb_clk_i);
        #1;
        chk("burst_full_count", 64'(count_o), 64'h4);
        chk("burst_full_stall", 64'(stall_o), 64'h1);
        req_i = 4'b0000;
        rd_i  = 1'b1;
        @(posedge wb_clk_i);
        #1;
        rd_i = 1'b0;
        chk("burst_pre_count", 64'(count_o), 64'h3);
        chk("burst_pre_stall", 64'(stall_o), 64'h1);
        #2 wb_rst_i = 1'b1;
        #1 chk_reset_state("async_rst");

        // A grant lost to reset is re-issued once reset releases.
        #2 wb_rst_i = 1'b0;
        req_i = 4'b0100;
        @(posedge wb_clk_i);
        #1;
        chk("lost_ack_first", 64'(ack_o), 64'h4);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("lost_ack_rst_ack", 64'(ack_o), 64'h0);
        chk("lost_ack_rst_count", 64'(count_o), 64'h0);
        #2 wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        chk("lost_ack_regrant", 64'(ack_o), 64'h4);
        chk("lost_ack_count", 64'(count_o), 64'h1);
        chk("lost_ack_data", 64'(rd_data_o), 64'(D2));
        req_i = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opentdc_rr_arbiter.md
# opentdc_rr_arbiter

Round-robin arbiter and readout FIFO for the OpenTDC timestamp channels. Collects completed timestamps from up to four TDC channels, grants one channel per cycle, and tags each timestamp with its channel number. The tagged entries go into a small first-word-fall-through FIFO that the Wishbone register block drains. It sits between the TDC channel cores and the Wishbone slave in `opentdc_wb`.

## Interface
Parameters:
- `TS_W`, 32: timestamp width per channel.
- `DEPTH`, 4: FIFO entries. Must be a power of 2, at least 2.

Ports:
- `wb_clk_i`  in  1  sole clock; all state changes on its rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  4  per-channel "timestamp ready". Level signal, held until the channel sees `ack_o`, dropped the cycle after.
- `ts_i`  in  4*TS_W  timestamps; channel k on bits [k*TS_W +: TS_W], stable while `req_i[k]`.
- `en_i`  in  4  channel enable mask; a disabled channel is never granted.
- `ack_o`  out  4  registered one-hot grant pulse, one cycle wide.
- `rd_i`  in  1  pop strobe from the Wishbone read of the data register.
- `rd_data_o`  out  TS_W+2  FIFO head, formatted {channel id[1:0], timestamp}.
- `empty_o`  out  1  FIFO empty.
- `full_o`  out  1  FIFO full.
- `count_o`  out  clog2(DEPTH)+1  number of entries held.
- `stall_o`  out  1  sticky flag: an enabled request was refused because the FIFO was full.
- `clr_i`  in  1  clears `stall_o`.

## Operation
- Eligible set = `req_i & en_i & ~ack_o`. The current `ack_o` is masked because that channel's request is still high during its ack cycle.
- Round-robin pointer `rr` holds the last granted index; reset value is 3.
- Search order is rr+1, rr+2, rr+3, rr (mod 4); the first eligible channel wins.
- A grant happens only when `count_o < DEPTH`, using the count before any same-cycle pop.
- On a grant to channel g, at the same edge:
  - `ack_o` is set to one-hot g.
  - {g, `ts_i[g]`} is written at the tail.
  - `rr` is set to g.
- With no grant, `ack_o` is 0 next cycle.
- Full FIFO:
  - no grant is issued and requests stay pending; no data is lost in the arbiter;
  - if any `req_i & en_i` bit is high, `stall_o` is set.
- `clr_i` clears `stall_o`. If clear and set conditions occur in the same cycle, set wins.
- `rd_i` with `empty_o` high is ignored. Otherwise the head pointer advances.
- Push and pop in the same cycle leave `count_o` unchanged. This is legal at any count from 1 to DEPTH-1.
- At count DEPTH: a pop is allowed; the push is blocked by the grant rule above.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `rd_data_o` always shows the entry at the head pointer. It is meaningful only when `empty_o` is low.
- Dropping `en_i[k]` never cancels an `ack_o` already issued. Entries already in the FIFO remain.

## Timing
- Reset (asynchronous, immediate):
  - `ack_o`=0, `count_o`=0, `empty_o`=1, `full_o`=0, `stall_o`=0, `rr`=3;
  - `rd_data_o`=0, with storage cleared.
- Latency from request to readout:
  - `req_i` high before edge N gives `ack_o` high in cycle N+1, with the entry written at edge N;
  - if the FIFO was empty, `rd_data_o` and `empty_o`=0 are valid in cycle N+1.
- Throughput: one grant per cycle.
- Two channels that both hold requests alternate grants on consecutive cycles, subject to masking of the just-acked channel.
- `count_o`, `empty_o` and `full_o` are registered and update at the same edge as the push or pop.
- Reset asserted mid-operation discards all entries and pending grants. A channel whose `ack_o` is lost keeps its request and is re-granted after reset release.

## Test plan
- Single request: after reset, `req_i`=0001 with `ts_i[0]`=0x00000A5A, enabled. Required:
  - `ack_o`=0001 for exactly one cycle;
  - `rd_data_o`={2'd0, 0x00000A5A};
  - `count_o`=1;
  - after `rd_i`, `empty_o`=1.
- Fairness: all four channels request continuously (each re-asserts 1 cycle after its ack), no reads, DEPTH=4. Required:
  - grant order 0,1,2,3;
  - `full_o`=1 after the 4th grant, then no `ack_o`;
  - `stall_o`=1.
- Full plus simultaneous pop:
  - at count 4 with `rd_i` and a pending request: `count_o` drops to 3 that cycle, with no push;
  - the next cycle grants and `count_o` returns to 4.
- Mask: `en_i`=1011 with all `req_i` high. Required: channel 2 is never acked; sequence 0,1,3,0.
- Wrap-around: push and pop 9 entries with distinct timestamps 1..9 while interleaving `rd_i`. Required: data read in order 1..9 with correct ids, and `empty_o`=1 at the end.
- Reset mid-burst: assert `wb_rst_i` asynchronously with count 3 and `stall_o`=1. Required: all outputs return to their reset values without waiting for a clock edge.
